sram_fetch: RTL and testbench

- Read initiator that feeds the SRAM buffer.
- On start_sram it reads the image region, then the weight region, from the on-chip SRAM.
- It streams each returned 32-bit word, tagged with region and index, to the buffer through a valid/ready handshake.
- It pulses sram_done when the last weight word has been accepted.
- It absorbs the fixed SRAM read latency with a credit-limited skid FIFO, so back-pressure never loses or duplicates a word.

---
 rtl/sram_fetch.sv | 245 ++++++++++++++++++++++++
 tb/tb_sram_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sram_fetch.sv
// sram_fetch: reads the image region then the weight region from on-chip SRAM
// and streams every returned word, tagged with region and index, to the buffer
// over a valid/ready handshake. A credit-limited skid FIFO absorbs the fixed
// SRAM read latency so back-pressure never drops or repeats a word.
module sram_fetch #(
  parameter int ADDR_W     = 16,
  parameter int IMG_BASE   = 0,
  parameter int IMG_WORDS  = 32,
  parameter int WGT_BASE   = 32,
  parameter int WGT_WORDS  = 512,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_sram,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_rdata,
  output logic [31:0]       sram_data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              data_is_image,
  output logic [9:0]        word_index,
  output logic              busy,
  output logic              sram_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IMG   = 3'd1,
    S_WGT   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Issue side: registered read request plus the tag that travels with it
  logic [9:0]        cnt_q, cnt_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tag_img_q, tag_img_d;
  logic [9:0]        tag_idx_q, tag_idx_d;

  // Return pipeline mirroring the SRAM latency
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] pimg_q, pimg_d;
  logic [9:0]        pidx_q [RD_LAT];
  logic [9:0]        pidx_d [RD_LAT];

  // Skid FIFO
  logic [31:0]      mem_data_q [FIFO_DEPTH];
  logic [31:0]      mem_data_d [FIFO_DEPTH];
  logic             mem_img_q  [FIFO_DEPTH];
  logic             mem_img_d  [FIFO_DEPTH];
  logic [9:0]       mem_idx_q  [FIFO_DEPTH];
  logic [9:0]       mem_idx_d  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic           push_s, pop_s, credit_ok_s, last_xfer_s;
  logic [PTR_W:0] count_next_s;
  logic [7:0]     in_flight_s, credit_sum_s;

  // Credit: FIFO occupancy after this edge plus reads still in the SRAM pipe
  always_comb begin
    push_s = vld_q[RD_LAT-1];
    pop_s  = (count_q != '0) && data_ready;
    count_next_s = count_q;
    if (push_s && !pop_s) begin
      count_next_s = count_q + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_next_s = count_q - CNT_ONE;
    end else begin
      count_next_s = count_q;
    end
    in_flight_s = {7'd0, ren_q};
    for (int i = 0; i < RD_LAT - 1; i++) begin
      in_flight_s = in_flight_s + {7'd0, vld_q[i]};
    end
    credit_sum_s = 8'(count_next_s) + in_flight_s;
    credit_ok_s  = credit_sum_s < 8'(FIFO_DEPTH);
    last_xfer_s  = pop_s && !mem_img_q[rd_ptr_q] &&
                   (mem_idx_q[rd_ptr_q] == 10'(WGT_WORDS - 1));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; region switches on the decision for the last read
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_sram) state_d = S_IMG; else state_d = S_IDLE;
      S_IMG:   if (credit_ok_s && (cnt_q == 10'(IMG_WORDS - 1))) state_d = S_WGT;
               else state_d = S_IMG;
      S_WGT:   if (credit_ok_s && (cnt_q == 10'(WGT_WORDS - 1))) state_d = S_DRAIN;
               else state_d = S_WGT;
      S_DRAIN: if (last_xfer_s) state_d = S_DONE; else state_d = S_DRAIN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    busy      = 1'b0;
    sram_done = 1'b0;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_DONE:  begin busy = 1'b1; sram_done = 1'b1; end
      default: busy = 1'b1;
    endcase
  end

  // Read issue: the first read is decided while start is sampled, later ones on credit
  always_comb begin
    ren_d     = 1'b0;
    addr_d    = '0;
    tag_img_d = 1'b0;
    tag_idx_d = 10'd0;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_sram) begin
          ren_d     = 1'b1;
          addr_d    = ADDR_W'(IMG_BASE);
          tag_img_d = 1'b1;
          tag_idx_d = 10'd0;
          cnt_d     = 10'd1;
        end else begin
          cnt_d = 10'd0;
        end
      end
      S_IMG: begin
        if (credit_ok_s) begin
          ren_d     = 1'b1;
          addr_d    = ADDR_W'(IMG_BASE) + ADDR_W'(cnt_q);
          tag_img_d = 1'b1;
          tag_idx_d = cnt_q;
          cnt_d     = (cnt_q == 10'(IMG_WORDS - 1)) ? 10'd0 : cnt_q + 10'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_WGT: begin
        if (credit_ok_s) begin
          ren_d     = 1'b1;
          addr_d    = ADDR_W'(WGT_BASE) + ADDR_W'(cnt_q);
          tag_img_d = 1'b0;
          tag_idx_d = cnt_q;
          cnt_d     = (cnt_q == 10'(WGT_WORDS - 1)) ? 10'd0 : cnt_q + 10'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = 10'd0;
    endcase
  end

  // Return pipeline shift and FIFO push/pop bookkeeping
  always_comb begin
    vld_d[0]  = ren_q;
    pimg_d[0] = tag_img_q;
    pidx_d[0] = tag_idx_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      pimg_d[i] = pimg_q[i-1];
      pidx_d[i] = pidx_q[i-1];
    end
    mem_data_d = mem_data_q;
    mem_img_d  = mem_img_q;
    mem_idx_d  = mem_idx_q;
    if (push_s) begin
      mem_data_d[wr_ptr_q] = sram_rdata;
      mem_img_d[wr_ptr_q]  = pimg_q[RD_LAT-1];
      mem_idx_d[wr_ptr_q]  = pidx_q[RD_LAT-1];
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_next_s;
  end

  // Datapath registers; reset discards any reads still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 10'd0;
      ren_q     <= 1'b0;
      addr_q    <= '0;
      tag_img_q <= 1'b0;
      tag_idx_q <= 10'd0;
      vld_q     <= '0;
      pimg_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) pidx_q[i] <= 10'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= 32'd0;
        mem_img_q[i]  <= 1'b0;
        mem_idx_q[i]  <= 10'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ren_q      <= ren_d;
      addr_q     <= addr_d;
      tag_img_q  <= tag_img_d;
      tag_idx_q  <= tag_idx_d;
      vld_q      <= vld_d;
      pimg_q     <= pimg_d;
      pidx_q     <= pidx_d;
      mem_data_q <= mem_data_d;
      mem_img_q  <= mem_img_d;
      mem_idx_q  <= mem_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign sram_ren      = ren_q;
  assign sram_addr     = addr_q;
  assign data_valid    = (count_q != '0);
  assign sram_data     = mem_data_q[rd_ptr_q];
  assign data_is_image = mem_img_q[rd_ptr_q];
  assign word_index    = mem_idx_q[rd_ptr_q];

endmodule

// File: tb/tb_sram_fetch.sv
// Bench for sram_fetch: table of load scenarios checked against an expected
// word list built from the region bases/sizes, plus reset and back-to-back sequences.
module tb_sram_fetch;

  localparam int IMG_BASE = 0, IMG_WORDS = 32, WGT_BASE = 32, WGT_WORDS = 512;
  localparam int DEPTH = 4;
  localparam int NW = IMG_WORDS + WGT_WORDS;

  logic        clk = 1'b0;
  logic        rst, start_sram, data_ready;
  logic        sram_ren;
  logic [15:0] sram_addr;
  logic [31:0] sram_rdata, sram_data, pipe1;
  logic        data_valid, data_is_image, busy, sram_done;
  logic [9:0]  word_index;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data [NW];
  logic        exp_img  [NW];
  int          exp_idx  [NW];

  typedef struct {
    int bp_lo; int bp_hi; bit rnd; int extra0; int extra1; int tail;
    int exp_first_ren; int exp_last_ren; int exp_first_val; int exp_last_val; int exp_done;
  } vec_t;
  vec_t vecs [4];

  sram_fetch dut (
    .clk(clk), .rst(rst), .start_sram(start_sram),
    .sram_ren(sram_ren), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .sram_data(sram_data), .data_valid(data_valid), .data_ready(data_ready),
    .data_is_image(data_is_image), .word_index(word_index),
    .busy(busy), .sram_done(sram_done)
  );

  always #5 clk = ~clk;

  // SRAM model: two-cycle latency, returns the address as data; never reset
  always @(posedge clk) begin
    pipe1      <= sram_ren ? {16'h0000, sram_addr} : 32'hDEAD_BEEF;
    sram_rdata <= pipe1;
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "/ren"}, sram_ren, 0);
    chk({nm, "/addr"}, sram_addr, 0);
    chk({nm, "/data"}, sram_data, 0);
    chk({nm, "/valid"}, data_valid, 0);
    chk({nm, "/is_image"}, data_is_image, 0);
    chk({nm, "/index"}, word_index, 0);
    chk({nm, "/busy"}, busy, 0);
    chk({nm, "/done"}, sram_done, 0);
  endtask

  // One full load; entry and exit are #1 after a rising edge
  task automatic run_load(input vec_t v, input string nm);
    int c, ren_n, xfer_n, done_n, done_cyc, first_ren, last_ren, first_val, last_val, busy_last;
    bit prev_v, prev_r, prev_i;
    logic [31:0] prev_d;
    logic [9:0]  prev_x;
    ren_n = 0; xfer_n = 0; done_n = 0; done_cyc = -1; busy_last = -1;
    first_ren = -1; last_ren = -1; first_val = -1; last_val = -1;
    prev_v = 0; prev_r = 0; prev_i = 0; prev_d = 32'd0; prev_x = 10'd0;
    c = 0;
    while (1) begin
      start_sram = (c == 0) || (c == v.extra0) || (c == v.extra1);
      if (v.rnd) data_ready = 1'($urandom_range(0, 1));
      else data_ready = !(c >= v.bp_lo && c <= v.bp_hi);
      @(negedge clk);
      if (c == 0) chk({nm, "/busy_c0"}, busy, 0);
      if (sram_ren) begin
        if (first_ren < 0) first_ren = c;
        last_ren = c;
        if (ren_n < NW) chk({nm, "/addr"}, sram_addr, exp_data[ren_n][15:0]);
        ren_n++;
      end
      if (data_valid) begin
        if (first_val < 0) first_val = c;
        last_val = c;
      end
      if (prev_v && !prev_r) begin
        chk({nm, "/hold_valid"}, data_valid, 1);
        chk({nm, "/hold_data"}, sram_data, prev_d);
        chk({nm, "/hold_tag"}, data_is_image, prev_i);
        chk({nm, "/hold_index"}, word_index, prev_x);
      end
      if (data_valid && data_ready) begin
        if (xfer_n < NW) begin
          chk({nm, "/data"}, sram_data, exp_data[xfer_n]);
          chk({nm, "/is_image"}, data_is_image, exp_img[xfer_n]);
          chk({nm, "/index"}, word_index, exp_idx[xfer_n]);
        end
        xfer_n++;
      end
      chk({nm, "/outstanding_le_depth"}, (ren_n - xfer_n) <= DEPTH, 1);
      if (sram_done) begin done_n++; done_cyc = c; end
      if (busy) busy_last = c;
      prev_v = data_valid; prev_r = data_ready; prev_d = sram_data;
      prev_i = data_is_image; prev_x = word_index;
      @(posedge clk); #1;
      if (done_cyc >= 0 && c >= done_cyc + v.tail) break;
      if (c >= 3000) begin
        chk({nm, "/timeout_done_seen"}, done_n, 1);
        break;
      end
      c++;
    end
    start_sram = 1'b0;
    data_ready = 1'b1;
    chk({nm, "/reads"}, ren_n, NW);
    chk({nm, "/words"}, xfer_n, NW);
    chk({nm, "/done_pulses"}, done_n, 1);
    chk({nm, "/busy_last_eq_done"}, busy_last, done_cyc);
    if (v.exp_first_ren >= 0) chk({nm, "/first_ren"}, first_ren, v.exp_first_ren);
    if (v.exp_last_ren  >= 0) chk({nm, "/last_ren"}, last_ren, v.exp_last_ren);
    if (v.exp_first_val >= 0) chk({nm, "/first_valid"}, first_val, v.exp_first_val);
    if (v.exp_last_val  >= 0) chk({nm, "/last_valid"}, last_val, v.exp_last_val);
    if (v.exp_done      >= 0) chk({nm, "/done_cycle"}, done_cyc, v.exp_done);
  endtask

  initial begin
    vec_t v;
    for (int k = 0; k < NW; k++) begin
      if (k < IMG_WORDS) begin
        exp_data[k] = 32'(IMG_BASE + k); exp_img[k] = 1'b1; exp_idx[k] = k;
      end else begin
        exp_data[k] = 32'(WGT_BASE + k - IMG_WORDS); exp_img[k] = 1'b0;
        exp_idx[k] = k - IMG_WORDS;
      end
    end
    //          bp_lo bp_hi rnd ex0  ex1  tail fren lren fval lval done
    vecs[0] = '{-1,   -1,   0,  -1,  -1,  20,  1,   544, 4,   547, 548};
    vecs[1] = '{10,   29,   0,  -1,  -1,  20,  1,   564, 4,   567, 568};
    vecs[2] = '{-1,   -1,   1,  -1,  -1,  20,  1,   -1,  4,   -1,  -1};
    vecs[3] = '{-1,   -1,   0,  100, 548, 20,  1,   544, 4,   547, 548};

    rst = 1'b1; start_sram = 1'b0; data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a load
    for (int c = 0; c < 200; c++) begin
      start_sram = (c == 0);
      @(posedge clk); #1;
    end
    start_sram = 1'b0;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("midrst/stale_valid", data_valid, 0);
      chk("midrst/stale_ren", sram_ren, 0);
      @(posedge clk); #1;
    end
    run_load(vecs[0], "after_rst");

    // Back-to-back loads: second start in the cycle after sram_done
    v = vecs[0];
    v.tail = 0;
    run_load(v, "b2b_first");
    run_load(vecs[0], "b2b_second");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
